// File: rtl/lsu_mem_ctrl.sv
// Load/store controller: turns RV32I byte-addressed loads/stores into word accesses
// on a synchronous-read memory, using read-modify-write for sub-word stores.
module lsu_mem_ctrl #(
    parameter int N = 10,
    parameter int M = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    input  logic         req_we,
    input  logic [2:0]   req_funct3,
    input  logic [31:0]  req_addr,
    input  logic [M-1:0] req_wdata,
    output logic         ready,
    output logic         done,
    output logic         err,
    output logic [M-1:0] rdata,
    output logic         mem_we,
    output logic [N-1:0] mem_a,
    output logic [M-1:0] mem_wd,
    input  logic [M-1:0] mem_rd
);

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_DATA,
        WR,
        ERR
    } state_t;

    state_t         state_q;
    logic [N-1:0]   idx_q;
    logic [1:0]     off_q;
    logic [2:0]     f3_q;
    logic           we_q;
    logic [M-1:0]   wd_q;
    logic [M-1:0]   rdata_q;
    logic           done_q;
    logic           err_q;

    logic           bad;
    logic [7:0]     byte_sel;
    logic [15:0]    half_sel;
    logic [M-1:0]   load_val;
    logic [M-1:0]   merged;
    logic           unused_addr;

    assign unused_addr = ^req_addr[31:N+2];

    assign ready  = (state_q == IDLE);
    assign done   = done_q;
    assign err    = err_q;
    assign rdata  = rdata_q;
    assign mem_we = (state_q == WR);
    assign mem_a  = idx_q;
    assign mem_wd = wd_q;

    // Illegal funct3 or misalignment of the incoming request
    always_comb begin
        bad = 1'b0;
        if (req_we) begin
            case (req_funct3)
                3'd0:    bad = 1'b0;
                3'd1:    bad = req_addr[0];
                3'd2:    bad = |req_addr[1:0];
                default: bad = 1'b1;
            endcase
        end else begin
            case (req_funct3)
                3'd0, 3'd4: bad = 1'b0;
                3'd1, 3'd5: bad = req_addr[0];
                3'd2:       bad = |req_addr[1:0];
                default:    bad = 1'b1;
            endcase
        end
    end

    always_comb begin
        case (off_q)
            2'd1:    byte_sel = mem_rd[15:8];
            2'd2:    byte_sel = mem_rd[23:16];
            2'd3:    byte_sel = mem_rd[31:24];
            default: byte_sel = mem_rd[7:0];
        endcase
        half_sel = off_q[1] ? mem_rd[31:16] : mem_rd[15:0];
        case (f3_q)
            3'd0:    load_val = {{24{byte_sel[7]}}, byte_sel};
            3'd1:    load_val = {{16{half_sel[15]}}, half_sel};
            3'd4:    load_val = {24'h0, byte_sel};
            3'd5:    load_val = {16'h0, half_sel};
            default: load_val = mem_rd;
        endcase
    end

    // Sub-word store merge: only SB (funct3 0) and SH (funct3 1) reach here
    always_comb begin
        merged = mem_rd;
        if (f3_q[0]) begin
            if (off_q[1]) merged[31:16] = wd_q[15:0];
            else          merged[15:0]  = wd_q[15:0];
        end else begin
            case (off_q)
                2'd1:    merged[15:8]  = wd_q[7:0];
                2'd2:    merged[23:16] = wd_q[7:0];
                2'd3:    merged[31:24] = wd_q[7:0];
                default: merged[7:0]   = wd_q[7:0];
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            off_q   <= '0;
            f3_q    <= '0;
            we_q    <= 1'b0;
            wd_q    <= '0;
            rdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        idx_q <= req_addr[N+1:2];
                        off_q <= req_addr[1:0];
                        f3_q  <= req_funct3;
                        we_q  <= req_we;
                        if (bad) begin
                            state_q <= ERR;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                            rdata_q <= '0;
                        end else if (req_we) begin
                            wd_q    <= req_wdata;
                            state_q <= (req_funct3 == 3'd2) ? WR : RD_WAIT;
                        end else begin
                            state_q <= RD_WAIT;
                        end
                    end
                end
                RD_WAIT: state_q <= RD_DATA;
                RD_DATA: begin
                    if (we_q) begin
                        wd_q    <= merged;
                        state_q <= WR;
                    end else begin
                        rdata_q <= load_val;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                WR: begin
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                ERR:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl: a transaction-level model predicts latency, result and
// memory effect of each request; one negedge process compares the DUT every cycle.
module tb_lsu_mem_ctrl;

    localparam int N = 10;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_we = 1'b0;
    logic [2:0]   req_funct3 = '0;
    logic [31:0]  req_addr = '0;
    logic [31:0]  req_wdata = '0;
    logic         ready, done, err, mem_we;
    logic [31:0]  rdata, mem_wd;
    logic [N-1:0] mem_a;
    logic [31:0]  mem_rd = '0;

    logic [31:0] sim_mem [0:(1<<N)-1] = '{default: '0};
    logic [31:0] ref_mem [0:(1<<N)-1] = '{default: '0};

    int checks = 0;
    int passes = 0;

    // Transaction model state
    int          phase = 0;
    int          t_lat = 0;
    logic        t_err = 1'b0;
    logic        t_store = 1'b0;
    logic [31:0] t_rdata = '0;
    logic [31:0] t_word = '0;
    logic [N-1:0] t_idx = '0;
    logic [31:0] last_rdata = '0;

    lsu_mem_ctrl #(.N(N), .M(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .ready(ready), .done(done), .err(err), .rdata(rdata),
        .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;

    // Synchronous-read data memory
    always @(posedge clk) begin
        if (mem_we) sim_mem[mem_a] <= mem_wd;
        mem_rd <= sim_mem[mem_a];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    endtask

    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd);
        int sz;
        int off;
        logic legal;
        logic [31:0] word, val;
        off = int'(a[1:0]);
        if (!we) legal = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
        else     legal = (f3 <= 2);
        sz = 1 << f3[1:0];
        if (off % sz != 0) legal = 1'b0;
        t_idx   = a[N+1:2];
        t_err   = !legal;
        t_store = we;
        word    = ref_mem[t_idx];
        if (!legal)  t_lat = 1;
        else if (!we) t_lat = 3;
        else         t_lat = (sz == 4) ? 2 : 4;
        val = word >> (8 * off);
        if (sz == 1)      val = f3[2] ? {24'h0, val[7:0]}  : {{24{val[7]}}, val[7:0]};
        else if (sz == 2) val = f3[2] ? {16'h0, val[15:0]} : {{16{val[15]}}, val[15:0]};
        t_rdata = val;
        t_word  = word;
        if (legal && we)
            for (int i = 0; i < sz; i++) t_word[8*(off+i) +: 8] = wd[8*i +: 8];
    endtask

    always @(negedge clk) begin
        if (phase == 0) begin
            chk("idle_ready", ready, 1);
            chk("idle_done", done, 0);
            chk("idle_err", err, 0);
            chk("idle_we", mem_we, 0);
            chk("idle_rdata", rdata, last_rdata);
        end else begin
            if (phase == t_lat) begin
                if (t_err)         last_rdata = '0;
                else if (!t_store) last_rdata = t_rdata;
            end
            chk("ready", ready, (phase == t_lat) && !t_err);
            chk("done", done, phase == t_lat);
            chk("err", err, (phase == t_lat) ? t_err : 1'b0);
            chk("rdata", rdata, last_rdata);
            chk("mem_we", mem_we, t_store && !t_err && (phase == t_lat - 1));
            if (phase < t_lat || t_err) chk("mem_a", 32'(mem_a), 32'(t_idx));
            if (t_store && !t_err && (phase == t_lat - 1)) chk("mem_wd", mem_wd, t_word);
            if (phase == t_lat) begin
                if (t_store && !t_err) ref_mem[t_idx] = t_word;
                phase = 0;
            end else begin
                phase++;
            end
        end
    end

    task automatic accept(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd);
        @(negedge clk); #1;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        model(we, f3, a, wd);
        @(posedge clk); #1;
        phase      = 1;
        req_valid  = 1'b0;
        req_we     = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input bit use_lit, input logic [31:0] lit,
                          input string nm);
        int n;
        accept(we, f3, a, wd);
        n = 0;
        while (phase != 0 && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        if (phase != 0) begin
            $display("FAIL %s: transaction did not complete within 20 cycles", nm);
            checks++;
            phase = 0;
        end
        if (use_lit) chk(nm, rdata, lit);
    endtask

    initial begin
        int bad_words;
        #2 rst = 1'b1;
        #1;
        chk("rst_ready", ready, 1);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_a", 32'(mem_a), 0);
        chk("rst_wd", mem_wd, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        do_req(1, 3'd2, 32'h10, 32'hDEADBEEF, 0, '0, "sw_10");
        do_req(0, 3'd2, 32'h10, '0, 1, 32'hDEADBEEF, "lw_10");
        do_req(0, 3'd0, 32'h13, '0, 1, 32'hFFFFFFDE, "lb_13");
        do_req(0, 3'd4, 32'h13, '0, 1, 32'h000000DE, "lbu_13");
        do_req(0, 3'd1, 32'h10, '0, 1, 32'hFFFFBEEF, "lh_10");
        do_req(0, 3'd5, 32'h12, '0, 1, 32'h0000DEAD, "lhu_12");
        do_req(1, 3'd0, 32'h11, 32'h000000AA, 1, 32'h0000DEAD, "sb_11");
        do_req(1, 3'd1, 32'h12, 32'h00001234, 0, '0, "sh_12");
        do_req(0, 3'd2, 32'h10, '0, 1, 32'h1234AAEF, "lw_merged");
        do_req(0, 3'd0, 32'h11, '0, 1, 32'hFFFFFFAA, "lb_11");
        do_req(0, 3'd1, 32'h12, '0, 1, 32'h00001234, "lh_12");

        do_req(0, 3'd2, 32'h02, '0, 1, 32'h0, "lw_misaligned");
        do_req(0, 3'd2, 32'h10, '0, 1, 32'h1234AAEF, "lw_refill");
        do_req(1, 3'd1, 32'h05, 32'hFFFF, 1, 32'h0, "sh_misaligned");
        do_req(0, 3'd3, 32'h10, '0, 1, 32'h0, "ld_f3_3");
        do_req(1, 3'd3, 32'h10, 32'h5, 1, 32'h0, "st_f3_3");

        do_req(1, 3'd2, 32'h1000, 32'h11111111, 0, '0, "sw_wrap");
        do_req(0, 3'd2, 32'h0, '0, 1, 32'h11111111, "lw_0");

        // Reset while the SB read-modify-write sits in its read-data cycle
        accept(1, 3'd0, 32'h10, 32'h00000055);
        @(posedge clk); #1;
        rst = 1'b1;
        phase = 0;
        last_rdata = '0;
        #1;
        chk("abort_ready", ready, 1);
        chk("abort_done", done, 0);
        chk("abort_we", mem_we, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        do_req(0, 3'd2, 32'h10, '0, 1, 32'h1234AAEF, "lw_after_abort");

        repeat (2) @(negedge clk);
        chk("word4", sim_mem[4], 32'h1234AAEF);
        chk("word0", sim_mem[0], 32'h11111111);
        bad_words = 0;
        for (int i = 0; i < (1 << N); i++)
            if (sim_mem[i] !== ref_mem[i]) bad_words++;
        chk("mem_image", 32'(bad_words), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
